gray_cen_sequencer: RTL and testbench
=====================================

// Module: gray_cen_sequencer
// PURPOSE
//  Run-control sequencer for the Gray-code counter. It drives the counter's count-enable (cen)
//  from a start command, using a programmable start delay and a burst length or free-running mode.
//  It also checks the counter's Gray output on every cycle and flags any transition that breaks
//  the single-bit-change rule.
//  It sits between the test/system controller and the counter's cen input.
// PARAMETERS
//  WIDTH  3  width of the monitored Gray count
//  DLY_W  4  width of start-delay field (max delay 2^DLY_W-1 cycles)
//  LEN_W  8  width of burst-length field (max burst 2^LEN_W-1 cycles)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous reset, active-high
//  start     in   1      start request, sampled only in IDLE
//  abort     in   1      stop request, any state
//  mode      in   1      0 = burst of `length` cycles, 1 = continuous until abort
//  delay     in   DLY_W  cen-low cycles between start and first cen-high cycle
//  length    in   LEN_W  cen-high cycles in burst mode
//  gray_in   in   WIDTH  counter Gray output
//  cen       out  1      counter enable (registered)
//  busy      out  1      1 in DELAY or RUN
//  done      out  1      one-cycle pulse at normal burst completion
//  gray_err  out  1      sticky Gray-rule violation flag
// BEHAVIOUR
//  Reset: state=IDLE; cen=0, busy=0, done=0, gray_err=0; checker history invalid.
//  All outputs are registered. Cycle numbering: start is sampled at edge 0.
//  FSM states: IDLE, DELAY, RUN.
//  - IDLE: if start & !abort: latch delay/length/mode into internal regs.
//    - delay!=0 -> DELAY, with dly_cnt=delay.
//    - delay==0 & (mode | length!=0) -> RUN.
//    - delay==0 & !mode & length==0 -> stay IDLE and pulse done at edge 1.
//  - DELAY: dly_cnt decrements each edge. At dly_cnt==1: go to RUN if (mode | length!=0);
//    otherwise go to IDLE and pulse done.
//  - RUN: cen=1.
//    - burst: len_cnt is loaded with length, decrements each cen-high cycle; after the last
//      cycle, cen=0, done=1 and state=IDLE on the same edge.
//    - continuous: stays in RUN until abort.
//  Timing: cen is high during cycles D+1 .. D+L (D = delay, L = length); done=1 in cycle D+L+1.
//  abort (DELAY/RUN): next edge -> IDLE, cen=0, busy=0; done is not asserted.
//    abort has priority over start, over burst completion in the same cycle, and over start in IDLE.
//  start while busy: ignored, and not queued. Input changes after acceptance have no effect.
//  busy = (state!=IDLE), registered with the state.
//  Gray checker:
//    - Each edge: gray_q<=gray_in, cen_q<=cen, hist_vld<=1.
//    - If hist_vld: require popcount(gray_in^gray_q)==1 when cen_q=1, and ==0 when cen_q=0.
//      A violation sets gray_err on that edge.
//    - Wrap (e.g. 100->000 for WIDTH=3) is legal, being a single-bit change.
//    - gray_err is cleared only by rst or by an accepted start.
//    - Checking runs in every state.
//  rst mid-operation: same as reset; the burst is discarded with no done pulse.
// TESTING
//  1 rst held 3 cycles with start=1 -> cen/busy/done/gray_err all 0; no start is accepted.
//  2 mode=0,delay=4,length=10,start@0 -> busy 1..14, cen 1 in cycles 5..14 (10 cycles), done=1
//    only in cycle 15.
//  3 mode=0,delay=0,length=0 -> cen never 1, busy never 1, done=1 in cycle 1;
//    and delay=0,length=1 -> cen high in cycle 1 only, done in cycle 2.
//  4 mode=1,delay=2,start@0; abort@9 -> cen high 3..9, cen=0 and busy=0 from cycle 10, done never 1.
//  5 start pulsed during RUN -> burst length unchanged; start & abort together in IDLE -> stays
//    IDLE, busy 0; abort in the final burst cycle -> no done.
//  6 model a Gray counter on cen, then force a 2-bit jump (011->000) -> gray_err=1 next edge and
//    stays 1; gray_in change while cen_q=0 -> gray_err; next accepted start clears it.

Source files
------------

// File: rtl/gray_cen_sequencer.sv
// Run-control sequencer for a Gray-code counter: drives the counter's cen from
// a start command (programmable start delay, burst length or free-running) and
// watches the counter output for breaks of the single-bit-change rule.
module gray_cen_sequencer #(
  parameter int WIDTH = 3,
  parameter int DLY_W = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [DLY_W-1:0] delay,
  input  logic [LEN_W-1:0] length,
  input  logic [WIDTH-1:0] gray_in,
  output logic             cen,
  output logic             busy,
  output logic             done,
  output logic             gray_err
);

  typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;

  state_t             state;
  logic [DLY_W-1:0]   dly_cnt;
  logic [LEN_W-1:0]   len_cnt;
  logic [LEN_W-1:0]   len_q;
  logic               mode_q;
  logic [WIDTH-1:0]   gray_q;
  logic               cen_q;
  logic               hist_vld;
  logic               acc;
  logic               viol;

  function automatic int popcount(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  // A start is taken only from IDLE, and abort always wins over it
  assign acc = (state == IDLE) && start && !abort;

  // One step between samples is legal only while the counter was enabled
  always_comb begin
    viol = hist_vld && (popcount(gray_in ^ gray_q) != int'(cen_q));
  end

  // Control FSM: state, cen, busy and done are all registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cen   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            if (delay != '0) begin
              state <= DELAY;
              busy  <= 1'b1;
            end else if (mode || (length != '0)) begin
              state <= RUN;
              busy  <= 1'b1;
              cen   <= 1'b1;
            end else begin
              done  <= 1'b1;
            end
          end
        end
        DELAY: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (dly_cnt == DLY_W'(1)) begin
            if (mode_q || (len_q != '0)) begin
              state <= RUN;
              cen   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            cen   <= 1'b0;
          end else if (!mode_q && (len_cnt == LEN_W'(1))) begin
            state <= IDLE;
            busy  <= 1'b0;
            cen   <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cen   <= 1'b0;
        end
      endcase
    end
  end

  // Latched burst parameters and down-counters; the FSM decides when they matter
  always_ff @(posedge clk) begin
    if (acc) begin
      mode_q  <= mode;
      len_q   <= length;
      dly_cnt <= delay;
      len_cnt <= length;
    end else if (state == DELAY) begin
      dly_cnt <= dly_cnt - DLY_W'(1);
      len_cnt <= len_q;
    end else if (state == RUN) begin
      len_cnt <= len_cnt - LEN_W'(1);
    end
  end

  // Checker history: previous Gray sample and the cen that was driving it
  always_ff @(posedge clk) begin
    gray_q <= gray_in;
    cen_q  <= cen;
  end

  // Sticky error flag; a violation on the accepting edge is kept, not lost
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld <= 1'b0;
      gray_err <= 1'b0;
    end else begin
      hist_vld <= 1'b1;
      if (viol)     gray_err <= 1'b1;
      else if (acc) gray_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_cen_sequencer.sv
// Self-checking bench for gray_cen_sequencer with a timeline-based reference model.
module tb_gray_cen_sequencer;
  localparam int WIDTH = 3;
  localparam int DLY_W = 4;
  localparam int LEN_W = 8;
  localparam int FOREVER_T = 32'h7fffffff;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             mode = 1'b0;
  logic [DLY_W-1:0] delay = '0;
  logic [LEN_W-1:0] length = '0;
  logic [WIDTH-1:0] gray_in = '0;
  logic             cen, busy, done, gray_err;

  int checks = 0;
  int failures = 0;

  // reference model: a transaction is a time window [e, re) with cen from rb
  int   t = 0;
  bit   has_tx = 0, aborted = 0, tx_mode = 0;
  int   e = 0, rb = 0, re = 0;
  bit   busy_m = 0, cen_m = 0, done_m = 0, err_m = 0, hist_m = 0, c_prev = 0;
  logic [WIDTH-1:0] g_prev = '0;
  logic [WIDTH-1:0] cnt = '0;

  gray_cen_sequencer #(.WIDTH(WIDTH), .DLY_W(DLY_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .delay(delay), .length(length), .gray_in(gray_in),
    .cen(cen), .busy(busy), .done(done), .gray_err(gray_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout t=%0d", t);
    $fatal(1, "timeout");
  end

  // Advance one edge: update the model from the inputs the DUT sees, then
  // move the modelled Gray counter according to the cen that was driving it.
  task automatic tick();
    bit cen_now, viol;
    bit acc;
    cen_now = cen;
    @(posedge clk);
    t++;
    viol = hist_m && ($countones(gray_in ^ g_prev) != (c_prev ? 1 : 0));
    acc = 0;
    if (rst) begin
      has_tx = 0; err_m = 0; hist_m = 0;
    end else begin
      if (busy_m && abort) begin
        re = t; aborted = 1;
      end else if (!busy_m && start && !abort) begin
        acc = 1; has_tx = 1; aborted = 0; e = t;
        rb = t + int'(delay); tx_mode = mode;
        re = mode ? FOREVER_T : t + int'(delay) + int'(length);
      end
      err_m  = viol || (err_m && !acc);
      hist_m = 1;
    end
    c_prev = cen_m;
    g_prev = gray_in;
    busy_m = has_tx && (t >= e) && (t < re);
    cen_m  = has_tx && (t >= rb) && (t < re);
    done_m = has_tx && !aborted && !tx_mode && (t == re);
    #1;
    if (cen_now) cnt = cnt + 1'b1;
    gray_in = cnt ^ (cnt >> 1);
  endtask

  task automatic test_reset();
    rst = 1; start = 1; mode = 0; delay = 0; length = 5;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({cen, busy, done, gray_err} !== 4'b0000) begin
        failures++;
        $display("FAIL reset k=%0d got cen/busy/done/err=%b want 0000", k, {cen, busy, done, gray_err});
      end
    end
    rst = 0; start = 0;
    tick();
    checks++;
    if ({cen, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_no_start got cen/busy/done=%b want 000", {cen, busy, done});
    end
  endtask

  task automatic test_burst();
    mode = 0; delay = 4; length = 10; start = 1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      start = 0; delay = 7; length = 3; mode = 1;
      checks += 3;
      if (cen !== (k >= 4 && k <= 13)) begin
        failures++; $display("FAIL burst_cen k=%0d got %b want %b", k, cen, (k >= 4 && k <= 13));
      end
      if (busy !== (k <= 13)) begin
        failures++; $display("FAIL burst_busy k=%0d got %b want %b", k, busy, (k <= 13));
      end
      if (done !== (k == 14)) begin
        failures++; $display("FAIL burst_done k=%0d got %b want %b", k, done, (k == 14));
      end
    end
    mode = 0;
  endtask

  task automatic test_zero_len();
    mode = 0; delay = 0; length = 0; start = 1;
    for (int k = 0; k <= 2; k++) begin
      tick();
      start = 0;
      checks += 3;
      if (cen !== 1'b0) begin failures++; $display("FAIL zero_cen k=%0d got %b want 0", k, cen); end
      if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy k=%0d got %b want 0", k, busy); end
      if (done !== (k == 0)) begin failures++; $display("FAIL zero_done k=%0d got %b want %b", k, done, (k == 0)); end
    end
    delay = 0; length = 1; start = 1;
    for (int k = 0; k <= 2; k++) begin
      tick();
      start = 0;
      checks += 2;
      if (cen !== (k == 0)) begin failures++; $display("FAIL len1_cen k=%0d got %b want %b", k, cen, (k == 0)); end
      if (done !== (k == 1)) begin failures++; $display("FAIL len1_done k=%0d got %b want %b", k, done, (k == 1)); end
    end
  endtask

  task automatic test_continuous_abort();
    mode = 1; delay = 2; length = 0; start = 1;
    for (int k = 0; k <= 12; k++) begin
      abort = (k == 9);
      tick();
      start = 0; abort = 0;
      checks += 3;
      if (cen !== (k >= 2 && k <= 8)) begin
        failures++; $display("FAIL cont_cen k=%0d got %b want %b", k, cen, (k >= 2 && k <= 8));
      end
      if (busy !== (k <= 8)) begin
        failures++; $display("FAIL cont_busy k=%0d got %b want %b", k, busy, (k <= 8));
      end
      if (done !== 1'b0) begin failures++; $display("FAIL cont_done k=%0d got %b want 0", k, done); end
    end
    mode = 0;
  endtask

  task automatic test_start_abort_corners();
    int highs;
    highs = 0;
    // start pulsed mid-burst must not restart or resize it
    mode = 0; delay = 1; length = 6; start = 1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      start = (k == 3); length = 2; delay = 0;
      if (cen === 1'b1) highs++;
    end
    start = 0;
    checks++;
    if (highs !== 6) begin failures++; $display("FAIL ignore_start cen_cycles got %0d want 6", highs); end
    // start together with abort in IDLE is refused
    start = 1; abort = 1; length = 4;
    tick();
    start = 0; abort = 0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL start_abort_idle busy got %b want 0", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL start_abort_idle2 busy got %b want 0", busy); end
    // abort in the last burst cycle suppresses done
    delay = 0; length = 3; start = 1;
    for (int k = 0; k <= 4; k++) begin
      abort = (k == 3);
      tick();
      start = 0; abort = 0;
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL abort_last done k=%0d got %b want 0", k, done); end
    end
    checks++;
    if ({cen, busy} !== 2'b00) begin failures++; $display("FAIL abort_last idle got %b want 00", {cen, busy}); end
  endtask

  task automatic test_gray();
    int guard;
    mode = 1; delay = 0; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (gray_err !== 1'b0) begin failures++; $display("FAIL gray_clean got %b want 0", gray_err); end
    guard = 0;
    while (gray_in !== 3'b011 && guard < 20) begin tick(); guard++; end
    checks++;
    if (gray_in !== 3'b011) begin failures++; $display("FAIL gray_reach got %b want 011", gray_in); end
    tick();
    gray_in = 3'b000; cnt = '0;
    tick();
    checks++;
    if (gray_err !== 1'b1) begin failures++; $display("FAIL gray_jump got %b want 1", gray_err); end
    abort = 1;
    tick();
    abort = 0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (gray_err !== 1'b1) begin failures++; $display("FAIL gray_sticky got %b want 1", gray_err); end
    mode = 0; delay = 5; length = 2; start = 1;
    tick();
    start = 0;
    checks++;
    if (gray_err !== 1'b0) begin failures++; $display("FAIL gray_clear got %b want 0", gray_err); end
    tick();
    gray_in = gray_in ^ 3'b001;
    tick();
    checks++;
    if (gray_err !== 1'b1) begin failures++; $display("FAIL gray_idle_change got %b want 1", gray_err); end
    abort = 1;
    tick();
    abort = 0;
    tick();
    tick();
    checks += 2;
    if (err_m !== 1'b1) begin failures++; $display("FAIL gray_model_state got %b want 1", err_m); end
    if (gray_err !== err_m) begin failures++; $display("FAIL gray_vs_model got %b want %b", gray_err, err_m); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst    = ($urandom_range(0, 99) == 0);
      start  = ($urandom_range(0, 3) == 0);
      abort  = ($urandom_range(0, 24) == 0);
      mode   = ($urandom_range(0, 6) == 0);
      delay  = DLY_W'($urandom_range(0, 5));
      length = LEN_W'($urandom_range(0, 8));
      tick();
      checks += 4;
      if (cen !== cen_m) begin failures++; $display("FAIL rand_cen t=%0d got %b want %b", t, cen, cen_m); end
      if (busy !== busy_m) begin failures++; $display("FAIL rand_busy t=%0d got %b want %b", t, busy, busy_m); end
      if (done !== done_m) begin failures++; $display("FAIL rand_done t=%0d got %b want %b", t, done, done_m); end
      if (gray_err !== err_m) begin failures++; $display("FAIL rand_err t=%0d got %b want %b", t, gray_err, err_m); end
      if ($urandom_range(0, 29) == 0) gray_in = gray_in ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
    end
    rst = 0; start = 0; abort = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_burst();
    test_zero_len();
    test_continuous_abort();
    test_start_abort_corners();
    test_gray();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
